// File: rtl/render_sched_pkg.sv
// Shared types and widths for the per-frame render sequencer.
package render_sched_pkg;

    localparam int POSE_W  = 17;
    localparam int ANGLE_W = 16;
    localparam int BLOCK_W = 5;
    localparam int ADDR_W  = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_RENDER = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_EDIT   = 3'd4
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_LATCH) || (s == ST_RENDER) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/render_sched_wdog.sv
// Clearable up-counter with a terminal flag raised once the count reaches a limit.
module render_sched_wdog #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             term
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign term = (count_q >= limit);

    // Counting stops at the limit so a stale count can never wrap past it.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && !term) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/render_sched.sv
// Frame sequencer: latches the camera pose, runs and drains the ray-cast pipeline,
// and serves block-map edits only between frames.
module render_sched
    import render_sched_pkg::*;
#(
    parameter int H_DISP    = 480,
    parameter int V_DISP    = 272,
    parameter int DRAIN_CYC = 16,
    parameter int TIMEOUT   = 2**20
) (
    input  logic               PPL_clk,
    input  logic               rst_n,
    input  logic               frame_req,
    input  logic [POSE_W-1:0]  pose_x,
    input  logic [POSE_W-1:0]  pose_y,
    input  logic [POSE_W-1:0]  pose_z,
    input  logic [ANGLE_W-1:0] angle_x,
    input  logic [ANGLE_W-1:0] angle_y,
    input  logic               pix_valid,
    input  logic               edit_req,
    input  logic [ADDR_W-1:0]  edit_addr,
    input  logic [BLOCK_W-1:0] edit_data,
    output logic               edit_ack,
    output logic               ppl_rst,
    output logic [POSE_W-1:0]  ppl_pos_x,
    output logic [POSE_W-1:0]  ppl_pos_y,
    output logic [POSE_W-1:0]  ppl_pos_z,
    output logic [ANGLE_W-1:0] ppl_angle_x,
    output logic [ANGLE_W-1:0] ppl_angle_y,
    output logic [ADDR_W-1:0]  map_wr_addr,
    output logic [BLOCK_W-1:0] map_wr_data,
    output logic               map_wr_en,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         drop_cnt,
    output logic               timeout_err
);

    localparam int NPIX = H_DISP * V_DISP;
    localparam int PIX_W = $clog2(NPIX);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [WD_W-1:0] WD_TIMEOUT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_DRAIN = WD_W'(DRAIN_CYC - 1);

    state_e state_q, state_d;

    logic [PIX_W-1:0]   pix_cnt_q;
    logic [POSE_W-1:0]  pos_x_q, pos_y_q, pos_z_q;
    logic [ANGLE_W-1:0] ang_x_q, ang_y_q;
    logic [15:0]        frame_cnt_q;
    logic [7:0]         drop_cnt_q;
    logic               abort_q;
    logic               timeout_err_q;

    logic               last_pix;
    logic               wd_clear;
    logic               wd_en;
    logic               wd_term;
    logic [WD_W-1:0]    wd_limit;

    assign last_pix = (state_q == ST_RENDER) && pix_valid && (pix_cnt_q == PIX_LAST);

    // One counter serves as the RENDER watchdog and then, restarted, as the DRAIN timer.
    assign wd_en    = (state_q == ST_RENDER) || (state_q == ST_DRAIN);
    assign wd_limit = (state_q == ST_DRAIN) ? WD_DRAIN : WD_TIMEOUT;
    assign wd_clear = (state_q == ST_LATCH) || ((state_q == ST_RENDER) && (state_d == ST_DRAIN));

    render_sched_wdog #(.WIDTH(WD_W)) u_wdog (
        .clk   (PPL_clk),
        .rst_n (rst_n),
        .clear (wd_clear),
        .en    (wd_en),
        .limit (wd_limit),
        .term  (wd_term)
    );

    always_ff @(posedge PPL_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_req) begin
                    state_d = ST_LATCH;
                end else if (edit_req) begin
                    state_d = ST_EDIT;
                end
            end
            ST_EDIT:   state_d = ST_IDLE;
            ST_LATCH:  state_d = ST_RENDER;
            ST_RENDER: begin
                if (last_pix || wd_term) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wd_term) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ppl_rst     = 1'b1;
        busy        = is_busy(state_q);
        map_wr_en   = 1'b0;
        edit_ack    = 1'b0;
        frame_done  = 1'b0;
        map_wr_addr = '0;
        map_wr_data = '0;
        case (state_q)
            ST_RENDER: ppl_rst = 1'b0;
            ST_DRAIN: begin
                ppl_rst    = 1'b0;
                frame_done = wd_term && !abort_q;
            end
            ST_EDIT: begin
                map_wr_en   = 1'b1;
                edit_ack    = 1'b1;
                map_wr_addr = edit_addr;
                map_wr_data = edit_data;
            end
            default: ;
        endcase
    end

    // A completing pixel takes precedence over a watchdog expiry in the same cycle.
    always_ff @(posedge PPL_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q     <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            pos_z_q       <= '0;
            ang_x_q       <= '0;
            ang_y_q       <= '0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            abort_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == ST_LATCH) begin
                pos_x_q   <= pose_x;
                pos_y_q   <= pose_y;
                pos_z_q   <= pose_z;
                ang_x_q   <= angle_x;
                ang_y_q   <= angle_y;
                pix_cnt_q <= '0;
                abort_q   <= 1'b0;
            end
            if ((state_q == ST_RENDER) && pix_valid && (pix_cnt_q != PIX_LAST)) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
            end
            if ((state_q == ST_RENDER) && wd_term && !last_pix) begin
                abort_q       <= 1'b1;
                timeout_err_q <= 1'b1;
            end
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (frame_req && busy && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign ppl_pos_x   = pos_x_q;
    assign ppl_pos_y   = pos_y_q;
    assign ppl_pos_z   = pos_z_q;
    assign ppl_angle_x = ang_x_q;
    assign ppl_angle_y = ang_y_q;
    assign frame_cnt   = frame_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule
